hyperbus_trans_arb: RTL
=======================

Name: hyperbus_trans_arb

Overview:
Shares the single HyperBus transfer channel (transfer descriptor, RX data and B response) between NumReq requesters in the system clock domain, upstream of the transfer/RX/B CDCs.
Grants one requester at a time with round-robin fairness. Holds the grant until that transfer completes: last RX beat for reads, B handshake for writes. Steers RX data and B responses back to the granted requester only.

Parameters:
NumReq, 2, number of requesters; must be >=2.
trans_t, logic, transfer descriptor type, passed through unchanged.
rx_t, logic, RX beat type, passed through unchanged.
TimeoutCycles, 1024, stall limit for the optional timeout; must be >=2.
IdxW, $clog2(NumReq), owner index width; derived, not overridden.

Ports:
clk_i  in  1  system clock.
rst_ni  in  1  asynchronous active-low reset.
req_trans_i  in  NumReq x trans_t  per-requester transfer descriptor.
req_write_i  in  NumReq  1 = write transfer (completes on B), 0 = read (completes on last RX).
req_valid_i  in  NumReq  transfer request valid.
req_ready_o  out  NumReq  transfer request accepted.
trans_o  out  trans_t  granted descriptor toward CDC.
trans_valid_o  out  1  descriptor valid.
trans_ready_i  in  1  descriptor accepted by CDC.
rx_i  in  rx_t  RX beat from CDC FIFO.
rx_last_i  in  1  final beat of the read.
rx_valid_i  in  1  RX beat valid.
rx_ready_o  out  1  RX beat accepted.
req_rx_o  out  rx_t  RX beat broadcast to all requesters.
req_rx_valid_o  out  NumReq  RX valid, owner only.
req_rx_ready_i  in  NumReq  RX ready per requester.
b_error_i  in  1  write error.
b_valid_i  in  1  B valid.
b_ready_o  out  1  B accepted.
req_b_error_o  out  1  B error broadcast to all requesters.
req_b_valid_o  out  NumReq  B valid, owner only.
req_b_ready_i  in  NumReq  B ready per requester.
owner_o  out  IdxW  current/last granted index.
busy_o  out  1  state != IDLE.
timeout_o  out  1  one-cycle pulse when a transfer is abandoned (optional feature).

Behaviour:
- FSM states: IDLE, ISSUE, WAIT_RX, WAIT_B.
- Reset: state IDLE; rr_ptr 0; owner_o 0; trans_o register 0; trans_valid_o 0; rx_ready_o, b_ready_o, req_rx_valid_o, req_b_valid_o, busy_o, timeout_o all 0.
- IDLE, arbitration:
  - Winner = first i with req_valid_i[i], scanning from rr_ptr upward modulo NumReq.
  - req_ready_o[winner] = 1 combinationally in the same cycle; all other req_ready_o bits = 0.
  - On that handshake: register descriptor, owner and write flag; set rr_ptr = winner+1 (wraps NumReq-1 -> 0); go to ISSUE.
  - No valid request: stay in IDLE.
- req_ready_o is 0 in every non-IDLE state.
- ISSUE:
  - trans_valid_o = 1; trans_o stable until handshake.
  - On trans_ready_i: go to WAIT_B if write, else WAIT_RX.
  - Latency: request handshake at cycle N -> trans_valid_o at N+1.
- WAIT_RX:
  - Combinational pass-through: req_rx_valid_o[owner] = rx_valid_i; rx_ready_o = req_rx_ready_i[owner].
  - On a beat handshake with rx_last_i = 1: go to IDLE.
- WAIT_B:
  - req_b_valid_o[owner] = b_valid_i; b_ready_o = req_b_ready_i[owner].
  - On handshake: go to IDLE.
- Stray traffic: RX or B arriving in any other state is back-pressured (ready 0) and never forwarded.
- Back-to-back transfers: IDLE may grant in the cycle after completion. Minimum per-transfer overhead is 2 cycles (IDLE + ISSUE).
- Simultaneous requests: the round-robin order alone decides. Requesters never hold off each other beyond one transfer each.
- A requester dropping req_valid_i before its handshake is legal; arbitration re-evaluates every IDLE cycle.
- Asynchronous reset mid-transfer returns to IDLE immediately. The surrounding CDCs are reset by the same reset.

Optional Feature:
- Macro: HYPERBUS_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT_RX/WAIT_B and on every RX/B handshake; it increments on every other cycle in those states.
  - When the counter reaches TimeoutCycles-1: go to IDLE and pulse timeout_o for 1 cycle.
  - The abandoned requester receives nothing further. Later stray beats are back-pressured as normal.
- Undefined: no counter; timeout_o tied to 0; WAIT states wait indefinitely.

Test Plan:
- Reset, then req_valid_i=01, read, trans_ready_i=1, 4 RX beats with last on beat 4 -> req_ready_o[0] at cycle 0; trans_valid_o at cycle 1; 4 beats on req_rx_valid_o[0] only; busy_o falls after beat 4.
- req_valid_i=11 held, all writes, immediate B each time -> grants alternate 0,1,0,1; owner_o follows; req_b_valid_o never asserted to a non-owner.
- Owner 1 read with req_rx_ready_i[1]=0 for 5 cycles -> rx_ready_o=0 for those cycles, beat held; requester 0's request stays unaccepted until the last beat.
- B pulse while in IDLE -> b_ready_o=0, no req_b_valid_o asserted; B is accepted only after a write is granted and issued.
- Reset asserted in WAIT_RX -> all outputs at reset values asynchronously; after release, state IDLE and rr_ptr 0.
- Macro defined, TimeoutCycles=8, read granted, no RX -> timeout_o pulses exactly 8 cycles after entering WAIT_RX; the next pending request is granted afterwards.

Source files
------------

// File: rtl/hyperbus_trans_arb.sv
// -----------------------------------------------------------------------------
// hyperbus_trans_arb
//
// Shares one HyperBus transfer channel (descriptor, RX data, B response)
// between NumReq requesters in the system clock domain. A round-robin arbiter
// grants one requester at a time. The grant is held until that transfer
// completes: the last RX beat for a read, or the B handshake for a write. RX
// and B traffic is steered back to the granted requester only.
//
// Optional feature (macro HYPERBUS_ARB_TIMEOUT_EN): a stall counter abandons a
// transfer after TimeoutCycles cycles without RX/B progress and pulses
// timeout_o for one cycle. Without the macro timeout_o is tied low and the
// wait states wait indefinitely.
//
// Ports:
//   clk_i, rst_ni                       system clock, async active-low reset
//   req_trans_i/req_write_i/req_valid_i per-requester descriptor request
//   req_ready_o                         per-requester accept (IDLE only)
//   trans_o/trans_valid_o/trans_ready_i granted descriptor toward the CDC
//   rx_i/rx_last_i/rx_valid_i/rx_ready_o   RX beats from the CDC
//   req_rx_o/req_rx_valid_o/req_rx_ready_i RX beats toward the owner
//   b_error_i/b_valid_i/b_ready_o          B response from the CDC
//   req_b_error_o/req_b_valid_o/req_b_ready_i B response toward the owner
//   owner_o                             current/last granted index
//   busy_o                              a transfer is in progress
//   timeout_o                           one-cycle pulse on abandoned transfer
// -----------------------------------------------------------------------------
module hyperbus_trans_arb #(
    parameter int  NumReq        = 2,
    parameter type trans_t       = logic,
    parameter type rx_t          = logic,
    parameter int  TimeoutCycles = 1024,
    parameter int  IdxW          = $clog2(NumReq)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  trans_t            req_trans_i [NumReq],
    input  logic [NumReq-1:0] req_write_i,
    input  logic [NumReq-1:0] req_valid_i,
    output logic [NumReq-1:0] req_ready_o,
    output trans_t            trans_o,
    output logic              trans_valid_o,
    input  logic              trans_ready_i,
    input  rx_t               rx_i,
    input  logic              rx_last_i,
    input  logic              rx_valid_i,
    output logic              rx_ready_o,
    output rx_t               req_rx_o,
    output logic [NumReq-1:0] req_rx_valid_o,
    input  logic [NumReq-1:0] req_rx_ready_i,
    input  logic              b_error_i,
    input  logic              b_valid_i,
    output logic              b_ready_o,
    output logic              req_b_error_o,
    output logic [NumReq-1:0] req_b_valid_o,
    input  logic [NumReq-1:0] req_b_ready_i,
    output logic [IdxW-1:0]   owner_o,
    output logic              busy_o,
    output logic              timeout_o
);

    // Elaboration-time parameter sanity checks.
    if (NumReq < 2) begin : g_chk_numreq
        $error("hyperbus_trans_arb: NumReq must be >= 2");
    end
    if (TimeoutCycles < 2) begin : g_chk_timeout
        $error("hyperbus_trans_arb: TimeoutCycles must be >= 2");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RX = 2'd2,
        WAIT_B  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] rr_ptr_q;
    logic [IdxW-1:0] owner_q;
    trans_t          trans_q;
    logic            write_q;

    logic            grant_found;
    logic [IdxW-1:0] grant_idx;
    logic [IdxW:0]   cand;
    logic            grant_fire;
    logic            rx_fire;
    logic            b_fire;

    // Round-robin pick: first valid requester at or after rr_ptr, modulo
    // NumReq. One extra bit on cand keeps the wrap correct for NumReq values
    // that are not a power of two.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NumReq; k++) begin
            cand = {1'b0, rr_ptr_q} + (IdxW+1)'(k);
            if (cand >= (IdxW+1)'(NumReq)) begin
                cand = cand - (IdxW+1)'(NumReq);
            end
            if (!grant_found && req_valid_i[cand[IdxW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[IdxW-1:0];
            end
        end
    end

    assign grant_fire = (state_q == IDLE) && grant_found;
    assign rx_fire    = rx_valid_i && req_rx_ready_i[owner_q];
    assign b_fire     = b_valid_i && req_b_ready_i[owner_q];

`ifdef HYPERBUS_ARB_TIMEOUT_EN
    localparam int CntW = $clog2(TimeoutCycles);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            timeout_q, timeout_d;
`endif

    // Next-state and channel handshake outputs.
    always_comb begin
        state_d       = state_q;
        trans_valid_o = 1'b0;
        rx_ready_o    = 1'b0;
        b_ready_o     = 1'b0;
`ifdef HYPERBUS_ARB_TIMEOUT_EN
        // Counter is zero everywhere outside the wait states, which also
        // gives the clear-on-entry behaviour.
        cnt_d         = '0;
        timeout_d     = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (grant_fire) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                trans_valid_o = 1'b1;
                if (trans_ready_i) begin
                    state_d = write_q ? WAIT_B : WAIT_RX;
                end
            end
            WAIT_RX: begin
                rx_ready_o = req_rx_ready_i[owner_q];
                if (rx_fire) begin
                    if (rx_last_i) begin
                        state_d = IDLE;
                    end
                end
`ifdef HYPERBUS_ARB_TIMEOUT_EN
                else if (cnt_q == CntW'(TimeoutCycles - 1)) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
`endif
            end
            WAIT_B: begin
                b_ready_o = req_b_ready_i[owner_q];
                if (b_fire) begin
                    state_d = IDLE;
                end
`ifdef HYPERBUS_ARB_TIMEOUT_EN
                else if (cnt_q == CntW'(TimeoutCycles - 1)) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            trans_q  <= '0;
            write_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant_fire) begin
                trans_q  <= req_trans_i[grant_idx];
                owner_q  <= grant_idx;
                write_q  <= req_write_i[grant_idx];
                rr_ptr_q <= (grant_idx == IdxW'(NumReq - 1)) ? '0
                                                             : grant_idx + IdxW'(1);
            end
        end
    end

`ifdef HYPERBUS_ARB_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

    // Per-requester steering. req_ready_o is masked while reset is held so a
    // requester never sees an accept that the held-in-reset state discards.
    for (genvar gi = 0; gi < NumReq; gi++) begin : g_req
        assign req_ready_o[gi]    = rst_ni && grant_fire && (grant_idx == IdxW'(gi));
        assign req_rx_valid_o[gi] = (state_q == WAIT_RX) && rx_valid_i && (owner_q == IdxW'(gi));
        assign req_b_valid_o[gi]  = (state_q == WAIT_B) && b_valid_i && (owner_q == IdxW'(gi));
    end

    assign trans_o       = trans_q;
    assign owner_o       = owner_q;
    assign busy_o        = (state_q != IDLE);
    assign req_rx_o      = rx_i;
    assign req_b_error_o = b_error_i;

endmodule
